branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Control-flow controller for the 4-bit CPU core.
- Watches the 8-phase instruction frame (cycle 0..7; M1 = cycle 3 carries OPR, M2 = cycle 4 carries OPA) and decodes the branch class: JCN, JUN, JMS, ISZ (two-word), and JIN, BBL (one-word).
- Drives the PC load port and stack push/pop, replacing the tied-off pcLoad/pcNew and push/pop.
- Drives the register increment for ISZ and the ACC load for BBL.

Parameters:
- STACK_DEPTH, 3, number of return-address levels; used only by the optional depth tracker.

Ports:
- clk  in  1  system clock (toggle clock)
- rstN  in  1  asynchronous active-low reset
- cycle  in  3  instruction phase 0..7 from clockReset
- romData  in  4  ROM nibble (OPR at cycle 3, OPA at cycle 4)
- pcAddr  in  12  current PC
- testFlag  in  1  TEST pin; JCN treats 0 as asserted
- carryFlag  in  1  carry flag
- accZero  in  1  1 when ACC == 0
- regDout  in  4  register-file read of the ISZ target register
- pairDout  in  8  register-pair read for JIN
- stackPcOut  in  12  top-of-stack return address
- pcLoad  out  1  PC load strobe, high for cycle 7 only
- pcNew  out  12  PC load value
- stackPush  out  1  push strobe, high for cycle 7 only
- stackPushAddr  out  12  return address to push
- stackPop  out  1  pop strobe, high for cycle 7 only
- regIncWe  out  1  ISZ register write strobe, high for cycle 6 only
- regIncAddr  out  4  ISZ register index
- regIncData  out  4  regDout + 1 (mod 16)
- accLoadWe  out  1  BBL ACC write strobe, high for cycle 7 only
- accLoadData  out  4  BBL immediate
- secondWord  out  1  high for the whole frame in which the second word is fetched
- stackErr  out  1  sticky stack overflow/underflow (optional feature)

Behaviour:
- Reset (async, rstN=0):
  - State goes to FIRST.
  - All strobes, secondWord and stackErr go to 0.
  - pcNew, stackPushAddr, regIncAddr, regIncData and accLoadData go to 0.
  - Latched OPR/OPA/cmd/addr registers are cleared.
  - Reset mid-frame abandons any pending two-word instruction; no strobe fires after reset release until a full frame has been decoded.
- Latching:
  - opr is latched on the clk edge ending cycle 3; opa on the edge ending cycle 4.
  - In FIRST the values land in opr1/opa1; in SECOND they land in the address byte addr8 = {opr, opa}.
  - wordAddr is latched at the edge ending cycle 0 (the pcAddr of the word being fetched).
  - nextPage = (wordAddr + 1)[11:8].
- States:
  - FIRST: at the edge ending cycle 7, if opr1 ∈ {0001 JCN, 0100 JUN, 0101 JMS, 0111 ISZ}, store the command and go to SECOND. Otherwise stay in FIRST.
  - SECOND: secondWord=1 throughout. At the edge ending cycle 7, return to FIRST unconditionally.
  - Other OPRs (including FIM 0010 rrr0) are ignored, so the PC increments normally.
- Strobe timing:
  - All strobes are registered: set on the edge entering the named cycle, cleared on the next edge.
  - Consumers sample them on the edge that ends that cycle.
  - pcLoad overrides the PC increment on that edge.
- Actions by instruction:
  - JUN (SECOND): pcNew = {opa1, addr8}; pcLoad.
  - JMS (SECOND): same pcNew and pcLoad, plus stackPush with stackPushAddr = wordAddr + 1 (wraps 0xFFF→0x000).
  - JCN (SECOND): with c = opa1:
    - jump = c[3] XOR ((c[2] & accZero) | (c[1] & carryFlag) | (c[0] & ~testFlag)).
    - Flags are sampled at the edge ending cycle 6.
    - If jump: pcNew = {nextPage, addr8}; pcLoad. Otherwise no strobe.
    - c = 0000 never jumps; c = 1000 always jumps.
  - ISZ (SECOND):
    - regIncAddr = opa1; regIncData = regDout + 1; regIncWe during cycle 6.
    - If regIncData != 0: pcLoad with pcNew = {nextPage, addr8}.
    - regDout = 1111 → writes 0000 and falls through.
  - JIN (FIRST, opr1 = 0011, opa1[0] = 1): pcNew = {nextPage, pairDout}; pcLoad. Pair selection is the register file's job via opa1[3:1].
  - BBL (FIRST, opr1 = 1100): stackPop, pcLoad with pcNew = stackPcOut, accLoadWe with accLoadData = opa1, all during the same cycle 7.
- Page boundary: when wordAddr = xFF, nextPage is the following page (0xF wraps to 0x0).

Optional Feature:
- BRSEQ_STACK_TRACK_EN defined:
  - Internal depth counter 0..STACK_DEPTH: +1 on JMS, −1 on BBL.
  - JMS at full depth or BBL at depth 0 sets stackErr (sticky until reset). Strobes are still issued and the counter saturates.
- BRSEQ_STACK_TRACK_EN undefined: no counter; stackErr tied to 0.

Test Plan:
- JUN at 0x010, words 0x4A/0x5C → secondWord during frame 2; pcLoad=1 in frame-2 cycle 7 only; pcNew=0xA5C.
- JMS at 0x020, words 0x51/0x23 → stackPush and pcLoad in same cycle 7; stackPushAddr=0x022; pcNew=0x123. Then BBL 0xC7 → stackPop, pcLoad, pcNew=0x022 (stackPcOut), accLoadWe with accLoadData=0x7.
- JCN 0x14 (accZero test) at 0x0FE, second word 0x33 → accZero=1 gives pcNew=0x133; accZero=0 gives no pcLoad. Also 0x19 with testFlag=0 → no jump.
- ISZ 0x75, second word 0x40 → regDout=0xE: regIncWe at cycle 6 with regIncData=0xF, then pcLoad. regDout=0xF: regIncData=0x0, no pcLoad.
- Assert rstN low during SECOND cycle 5 of a JUN → all outputs 0 at once. After release, no pcLoad until the next complete JUN; FIM 0x20 alone produces no strobes.
- BRSEQ_STACK_TRACK_EN: 4 JMS with STACK_DEPTH=3 → stackErr rises at the 4th push. Without the macro, stackErr stays 0.

Source files
------------

// File: rtl/branch_sequencer.sv
// branch_sequencer: decodes JCN/JUN/JMS/ISZ/JIN/BBL over the 8-phase frame and drives PC/stack/reg/ACC strobes.
// Define BRSEQ_STACK_TRACK_EN to enable the return-stack depth tracker and sticky stackErr.
module branch_sequencer #(
  parameter int STACK_DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rstN_i,
  input  logic [2:0]  cycle_i,
  input  logic [3:0]  romData_i,
  input  logic [11:0] pcAddr_i,
  input  logic        testFlag_i,
  input  logic        carryFlag_i,
  input  logic        accZero_i,
  input  logic [3:0]  regDout_i,
  input  logic [7:0]  pairDout_i,
  input  logic [11:0] stackPcOut_i,
  output logic        pcLoad_o,
  output logic [11:0] pcNew_o,
  output logic        stackPush_o,
  output logic [11:0] stackPushAddr_o,
  output logic        stackPop_o,
  output logic        regIncWe_o,
  output logic [3:0]  regIncAddr_o,
  output logic [3:0]  regIncData_o,
  output logic        accLoadWe_o,
  output logic [3:0]  accLoadData_o,
  output logic        secondWord_o,
  output logic        stackErr_o
);

  typedef enum logic {FIRST = 1'b0, SECOND = 1'b1} state_t;

  localparam logic [3:0] OP_JCN = 4'b0001;
  localparam logic [3:0] OP_JIN = 4'b0011;
  localparam logic [3:0] OP_JUN = 4'b0100;
  localparam logic [3:0] OP_JMS = 4'b0101;
  localparam logic [3:0] OP_ISZ = 4'b0111;
  localparam logic [3:0] OP_BBL = 4'b1100;

  state_t      state_q;
  logic        synced_q;
  logic [3:0]  opr1_q, opa1_q, cmd_q;
  logic [7:0]  addr8_q;
  logic [11:0] word_addr_q;
  logic        pc_load_q, stack_push_q, stack_pop_q, reg_inc_we_q, acc_load_we_q, second_word_q;
  logic [11:0] pc_new_q, stack_push_addr_q;
  logic [3:0]  reg_inc_addr_q, reg_inc_data_q, acc_load_data_q;

  logic [11:0] word_addr_inc;
  logic [11:0] near_target, far_target;
  logic        jcn_jump, two_word;

  assign word_addr_inc = word_addr_q + 12'd1;
  assign near_target   = {word_addr_inc[11:8], addr8_q};
  assign far_target    = {opa1_q, addr8_q};
  assign jcn_jump      = opa1_q[3] ^ ((opa1_q[2] & accZero_i) | (opa1_q[1] & carryFlag_i) |
                                      (opa1_q[0] & ~testFlag_i));
  assign two_word      = opr1_q inside {OP_JCN, OP_JUN, OP_JMS, OP_ISZ};

  // synced_q stays low until a frame is seen from cycle 0, so a frame cut by reset never acts.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      state_q           <= FIRST;
      synced_q          <= 1'b0;
      opr1_q            <= 4'd0;
      opa1_q            <= 4'd0;
      cmd_q             <= 4'd0;
      addr8_q           <= 8'd0;
      word_addr_q       <= 12'd0;
      pc_load_q         <= 1'b0;
      stack_push_q      <= 1'b0;
      stack_pop_q       <= 1'b0;
      reg_inc_we_q      <= 1'b0;
      acc_load_we_q     <= 1'b0;
      second_word_q     <= 1'b0;
      pc_new_q          <= 12'd0;
      stack_push_addr_q <= 12'd0;
      reg_inc_addr_q    <= 4'd0;
      reg_inc_data_q    <= 4'd0;
      acc_load_data_q   <= 4'd0;
    end else begin
      pc_load_q     <= 1'b0;
      stack_push_q  <= 1'b0;
      stack_pop_q   <= 1'b0;
      reg_inc_we_q  <= 1'b0;
      acc_load_we_q <= 1'b0;
      case (cycle_i)
        3'd0: begin
          word_addr_q <= pcAddr_i;
          synced_q    <= 1'b1;
        end
        3'd3: begin
          if (state_q == FIRST) opr1_q <= romData_i;
          else                  addr8_q[7:4] <= romData_i;
        end
        3'd4: begin
          if (state_q == FIRST) opa1_q <= romData_i;
          else                  addr8_q[3:0] <= romData_i;
        end
        3'd5: begin
          if (synced_q && state_q == SECOND && cmd_q == OP_ISZ) begin
            reg_inc_we_q   <= 1'b1;
            reg_inc_addr_q <= opa1_q;
            reg_inc_data_q <= regDout_i + 4'd1;
          end
        end
        3'd6: begin
          if (synced_q) begin
            if (state_q == SECOND) begin
              case (cmd_q)
                OP_JUN: begin
                  pc_load_q <= 1'b1;
                  pc_new_q  <= far_target;
                end
                OP_JMS: begin
                  pc_load_q         <= 1'b1;
                  pc_new_q          <= far_target;
                  stack_push_q      <= 1'b1;
                  stack_push_addr_q <= word_addr_inc;
                end
                OP_JCN: begin
                  if (jcn_jump) begin
                    pc_load_q <= 1'b1;
                    pc_new_q  <= near_target;
                  end
                end
                OP_ISZ: begin
                  if (reg_inc_data_q != 4'd0) begin
                    pc_load_q <= 1'b1;
                    pc_new_q  <= near_target;
                  end
                end
                default: ;
              endcase
            end else if (opr1_q == OP_JIN && opa1_q[0]) begin
              pc_load_q <= 1'b1;
              pc_new_q  <= {word_addr_inc[11:8], pairDout_i};
            end else if (opr1_q == OP_BBL) begin
              pc_load_q       <= 1'b1;
              pc_new_q        <= stackPcOut_i;
              stack_pop_q     <= 1'b1;
              acc_load_we_q   <= 1'b1;
              acc_load_data_q <= opa1_q;
            end
          end
        end
        3'd7: begin
          if (state_q == SECOND) begin
            state_q       <= FIRST;
            second_word_q <= 1'b0;
          end else if (synced_q && two_word) begin
            state_q       <= SECOND;
            cmd_q         <= opr1_q;
            second_word_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pcLoad_o        = pc_load_q;
  assign pcNew_o         = pc_new_q;
  assign stackPush_o     = stack_push_q;
  assign stackPushAddr_o = stack_push_addr_q;
  assign stackPop_o      = stack_pop_q;
  assign regIncWe_o      = reg_inc_we_q;
  assign regIncAddr_o    = reg_inc_addr_q;
  assign regIncData_o    = reg_inc_data_q;
  assign accLoadWe_o     = acc_load_we_q;
  assign accLoadData_o   = acc_load_data_q;
  assign secondWord_o    = second_word_q;

`ifdef BRSEQ_STACK_TRACK_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [DW-1:0] depth_q;
  logic          stack_err_q;
  logic          jms_fire, bbl_fire;

  assign jms_fire = synced_q && cycle_i == 3'd6 && state_q == SECOND && cmd_q == OP_JMS;
  assign bbl_fire = synced_q && cycle_i == 3'd6 && state_q == FIRST && opr1_q == OP_BBL;

  // Counter saturates; the strobes themselves are never suppressed.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      depth_q     <= '0;
      stack_err_q <= 1'b0;
    end else if (jms_fire) begin
      if (depth_q == DW'(STACK_DEPTH)) stack_err_q <= 1'b1;
      else                             depth_q <= depth_q + DW'(1);
    end else if (bbl_fire) begin
      if (depth_q == '0) stack_err_q <= 1'b1;
      else               depth_q <= depth_q - DW'(1);
    end
  end

  assign stackErr_o = stack_err_q;
`else
  // Depth only matters with the tracker; this keeps the parameter referenced and is always 0.
  assign stackErr_o = (STACK_DEPTH < 0);
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Table-driven scoreboard bench for branch_sequencer: one record per instruction frame.
module tb_branch_sequencer;

`ifdef BRSEQ_STACK_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN_i;
  logic [2:0]  cycle_i;
  logic [3:0]  romData_i;
  logic [11:0] pcAddr_i;
  logic        testFlag_i, carryFlag_i, accZero_i;
  logic [3:0]  regDout_i;
  logic [7:0]  pairDout_i;
  logic [11:0] stackPcOut_i;
  logic        pcLoad_o, stackPush_o, stackPop_o, regIncWe_o, accLoadWe_o, secondWord_o, stackErr_o;
  logic [11:0] pcNew_o, stackPushAddr_o;
  logic [3:0]  regIncAddr_o, regIncData_o, accLoadData_o;

  always #5 clk = ~clk;

  branch_sequencer #(.STACK_DEPTH(3)) dut (
    .clk_i(clk), .rstN_i(rstN_i), .cycle_i(cycle_i), .romData_i(romData_i),
    .pcAddr_i(pcAddr_i), .testFlag_i(testFlag_i), .carryFlag_i(carryFlag_i),
    .accZero_i(accZero_i), .regDout_i(regDout_i), .pairDout_i(pairDout_i),
    .stackPcOut_i(stackPcOut_i), .pcLoad_o(pcLoad_o), .pcNew_o(pcNew_o),
    .stackPush_o(stackPush_o), .stackPushAddr_o(stackPushAddr_o), .stackPop_o(stackPop_o),
    .regIncWe_o(regIncWe_o), .regIncAddr_o(regIncAddr_o), .regIncData_o(regIncData_o),
    .accLoadWe_o(accLoadWe_o), .accLoadData_o(accLoadData_o),
    .secondWord_o(secondWord_o), .stackErr_o(stackErr_o)
  );

  logic [42:0] all_outs;
  assign all_outs = {pcLoad_o, pcNew_o, stackPush_o, stackPushAddr_o, stackPop_o, regIncWe_o,
                     regIncAddr_o, regIncData_o, accLoadWe_o, accLoadData_o, secondWord_o, stackErr_o};

  typedef struct {
    logic [11:0] pc;
    logic [7:0]  word;
    logic        az, cy, tst;
    logic [3:0]  rd;
    logic [7:0]  pair;
    logic [11:0] stk;
    logic        sw, ld;
    logic [11:0] pcn;
    logic        push;
    logic [11:0] pa;
    logic        pop, incwe;
    logic [3:0]  inca, incd;
    logic        accwe;
    logic [3:0]  accd;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t fr(input logic [11:0] pc, input logic [7:0] word, input logic sw);
    vec_t v;
    v.pc = pc; v.word = word; v.az = 1'b0; v.cy = 1'b0; v.tst = 1'b1;
    v.rd = 4'h0; v.pair = 8'h00; v.stk = 12'h000;
    v.sw = sw; v.ld = 1'b0; v.pcn = 12'h000; v.push = 1'b0; v.pa = 12'h000;
    v.pop = 1'b0; v.incwe = 1'b0; v.inca = 4'h0; v.incd = 4'h0;
    v.accwe = 1'b0; v.accd = 4'h0; v.err = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s pc=%03h cycle=%0d: got %0h expected %0h", name, pcAddr_i, cycle_i, act, exp);
    end
  endtask

  task automatic observe(input int c);
    vec_t       e;
    logic [4:0] strb;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty at cycle %0d", c);
      return;
    end
    e    = sb[0];
    strb = {pcLoad_o, stackPush_o, stackPop_o, accLoadWe_o, regIncWe_o};
    case (c)
      0: begin
        check("second_word_c0", secondWord_o, e.sw);
        check("strobes_idle", strb, 5'b0);
      end
      6: begin
        check("strobes_c6", strb, {4'b0, e.incwe});
        if (e.incwe) begin
          check("reg_inc_addr", regIncAddr_o, e.inca);
          check("reg_inc_data", regIncData_o, e.incd);
        end
      end
      7: begin
        check("strobes_c7", strb, {e.ld, e.push, e.pop, e.accwe, 1'b0});
        if (e.ld)    check("pc_new", pcNew_o, e.pcn);
        if (e.push)  check("stack_push_addr", stackPushAddr_o, e.pa);
        if (e.accwe) check("acc_load_data", accLoadData_o, e.accd);
        check("second_word_c7", secondWord_o, e.sw);
        check("stack_err", stackErr_o, e.err);
        void'(sb.pop_front());
        $display("frame pc=%03h word=%02h sw=%0b ld=%0b pcn=%03h push=%0b pop=%0b accwe=%0b err=%0b",
                 e.pc, e.word, secondWord_o, pcLoad_o, pcNew_o, stackPush_o, stackPop_o, accLoadWe_o, stackErr_o);
      end
      default: check("strobes_idle", strb, 5'b0);
    endcase
  endtask

  task automatic run_frame(input vec_t v);
    sb.push_back(v);
    pcAddr_i = v.pc; accZero_i = v.az; carryFlag_i = v.cy; testFlag_i = v.tst;
    regDout_i = v.rd; pairDout_i = v.pair; stackPcOut_i = v.stk;
    for (int c = 0; c < 8; c++) begin
      cycle_i   = 3'(c);
      romData_i = (c == 3) ? v.word[7:4] : (c == 4) ? v.word[3:0] : 4'h0;
      @(negedge clk);
      observe(c);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vec_t v;
    rstN_i = 1'b0; cycle_i = 3'd0; romData_i = 4'h0; pcAddr_i = 12'h000;
    testFlag_i = 1'b1; carryFlag_i = 1'b0; accZero_i = 1'b0;
    regDout_i = 4'h0; pairDout_i = 8'h00; stackPcOut_i = 12'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", all_outs, 43'd0);
    @(posedge clk);
    #1;
    rstN_i = 1'b1;

    // JUN
    tbl.push_back(fr(12'h010, 8'h4A, 1'b0));
    v = fr(12'h011, 8'h5C, 1'b1); v.ld = 1; v.pcn = 12'hA5C; tbl.push_back(v);
    // JMS then BBL
    tbl.push_back(fr(12'h020, 8'h51, 1'b0));
    v = fr(12'h021, 8'h23, 1'b1); v.ld = 1; v.pcn = 12'h123; v.push = 1; v.pa = 12'h022; tbl.push_back(v);
    v = fr(12'h123, 8'hC7, 1'b0); v.stk = 12'h022; v.ld = 1; v.pcn = 12'h022; v.pop = 1;
    v.accwe = 1; v.accd = 4'h7; tbl.push_back(v);
    // JCN accZero across page boundary, taken and not taken
    tbl.push_back(fr(12'h0FE, 8'h14, 1'b0));
    v = fr(12'h0FF, 8'h33, 1'b1); v.az = 1; v.ld = 1; v.pcn = 12'h133; tbl.push_back(v);
    tbl.push_back(fr(12'h0FE, 8'h14, 1'b0));
    v = fr(12'h0FF, 8'h33, 1'b1); v.az = 0; tbl.push_back(v);
    // JCN inverted TEST: testFlag=0 no jump, testFlag=1 jump
    tbl.push_back(fr(12'h0FE, 8'h19, 1'b0));
    v = fr(12'h0FF, 8'h33, 1'b1); v.tst = 0; tbl.push_back(v);
    tbl.push_back(fr(12'h0FE, 8'h19, 1'b0));
    v = fr(12'h0FF, 8'h33, 1'b1); v.tst = 1; v.ld = 1; v.pcn = 12'h133; tbl.push_back(v);
    // JCN c=0000 never, c=1000 always (with top-page wrap)
    tbl.push_back(fr(12'h050, 8'h10, 1'b0));
    v = fr(12'h051, 8'h66, 1'b1); v.az = 1; v.cy = 1; v.tst = 0; tbl.push_back(v);
    tbl.push_back(fr(12'hFFE, 8'h18, 1'b0));
    v = fr(12'hFFF, 8'hAB, 1'b1); v.ld = 1; v.pcn = 12'h0AB; tbl.push_back(v);
    // ISZ non-zero result jumps, wrap to zero falls through
    tbl.push_back(fr(12'h040, 8'h75, 1'b0));
    v = fr(12'h041, 8'h40, 1'b1); v.rd = 4'hE; v.incwe = 1; v.inca = 4'h5; v.incd = 4'hF;
    v.ld = 1; v.pcn = 12'h040; tbl.push_back(v);
    tbl.push_back(fr(12'h040, 8'h75, 1'b0));
    v = fr(12'h041, 8'h40, 1'b1); v.rd = 4'hF; v.incwe = 1; v.inca = 4'h5; v.incd = 4'h0; tbl.push_back(v);
    // JIN at end of page; FIN (opa[0]=0) ignored; FIM ignored
    v = fr(12'h1FF, 8'h33, 1'b0); v.pair = 8'h9C; v.ld = 1; v.pcn = 12'h29C; tbl.push_back(v);
    v = fr(12'h1FF, 8'h32, 1'b0); v.pair = 8'h9C; tbl.push_back(v);
    tbl.push_back(fr(12'h060, 8'h20, 1'b0));
    tbl.push_back(fr(12'h061, 8'h00, 1'b0));
    // JMS return address wraps 0xFFF -> 0x000
    tbl.push_back(fr(12'hFFE, 8'h5F, 1'b0));
    v = fr(12'hFFF, 8'h00, 1'b1); v.ld = 1; v.pcn = 12'hF00; v.push = 1; v.pa = 12'h000; tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) run_frame(tbl[i]);

    // Reset during SECOND cycle 5 of a JUN
    run_frame(fr(12'h300, 8'h4A, 1'b0));
    pcAddr_i = 12'h301;
    for (int c = 0; c < 5; c++) begin
      cycle_i   = 3'(c);
      romData_i = (c == 3) ? 4'h5 : (c == 4) ? 4'hC : 4'h0;
      @(posedge clk);
      #1;
    end
    cycle_i = 3'd5; romData_i = 4'h0;
    #1;
    check("second_word_before_reset", secondWord_o, 1'b1);
    rstN_i = 1'b0;
    #1;
    check("reset_mid_frame", all_outs, 43'd0);
    @(posedge clk);
    #1;
    cycle_i = 3'd6; rstN_i = 1'b1;
    @(posedge clk);
    #1;
    cycle_i = 3'd7;
    @(negedge clk);
    check("no_load_after_reset", {pcLoad_o, secondWord_o}, 2'b00);
    @(posedge clk);
    #1;
    run_frame(fr(12'h302, 8'h20, 1'b0));
    run_frame(fr(12'h303, 8'h00, 1'b0));
    run_frame(fr(12'h304, 8'h4A, 1'b0));
    v = fr(12'h305, 8'h5C, 1'b1); v.ld = 1; v.pcn = 12'hA5C; run_frame(v);

    // Four nested JMS from a fresh reset: overflow flagged only with the tracker
    rstN_i = 1'b0;
    @(posedge clk);
    #1;
    rstN_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_frame(fr(12'(12'h100 + 2 * k), 8'h51, 1'b0));
      v = fr(12'(12'h101 + 2 * k), 8'h00, 1'b1);
      v.ld = 1; v.pcn = 12'h100; v.push = 1; v.pa = 12'(12'h102 + 2 * k);
      v.err = TRACK && (k == 3);
      run_frame(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
